// File: rtl/note_detector.sv
// ---------------------------------------------------------------------------
// note_detector
//   Pitch detector for a sampled audio stream. A hysteresis zero-crossing FSM
//   measures the period (in samples) between rising crossings, a boundary
//   table classifies each period into a note index, and a stability tracker
//   only updates the note after STABLE_N identical classifications in a row.
//
// Ports
//   clk          : system clock, rising-edge
//   reset        : asynchronous, active-high reset
//   sample_valid : one-cycle strobe qualifying sample
//   sample       : signed 16-bit audio sample
//   note         : note index, 0 = C2 .. 47 = B5, 63 = no note
//   note_valid   : high when note != 63
//   note_changed : one-cycle pulse when note takes a new value
//   period       : last completed period, in samples
// ---------------------------------------------------------------------------
module note_detector #(
  parameter logic signed [15:0] HYST     = 16'sd512,
  parameter int                 STABLE_N = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sample_valid,
  input  logic signed [15:0] sample,
  output logic [5:0]         note,
  output logic               note_valid,
  output logic               note_changed,
  output logic [9:0]         period
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_ARM      = 2'd1;
  localparam logic [1:0] S_RUN_HIGH = 2'd2;
  localparam logic [1:0] S_RUN_LOW  = 2'd3;

  localparam logic [5:0] NO_NOTE    = 6'd63;
  localparam int         CW         = $clog2(STABLE_N + 1);
  localparam logic [CW-1:0] STABLE_MAX = CW'(STABLE_N);

  logic [1:0]         state;
  logic [9:0]         count;
  logic [9:0]         count_inc;
  logic signed [15:0] neg_hyst;
  logic               is_high;
  logic               is_low;
  logic               running;
  logic               rise;
  logic               timeout;

  logic [9:0]         pend_p;
  logic               pend_valid;
  logic [5:0]         cand_next;
  logic [5:0]         cand_q;
  logic               cand_valid;

  logic [5:0]         last_cand;
  logic [CW-1:0]      stable_cnt;
  logic [5:0]         trk_last_next;
  logic [CW-1:0]      trk_cnt_next;
  logic               update_note;

  // Boundary table: period upper bounds halfway (in log-frequency) below each
  // semitone, so a period P belongs to note k when B[k+1] < P <= B[k].
  function automatic logic [9:0] bound(input int k);
    case (k)
      0:  return 10'd755;  1:  return 10'd712;  2:  return 10'd672;
      3:  return 10'd635;  4:  return 10'd599;  5:  return 10'd565;
      6:  return 10'd534;  7:  return 10'd504;  8:  return 10'd475;
      9:  return 10'd449;  10: return 10'd423;  11: return 10'd400;
      12: return 10'd377;  13: return 10'd356;  14: return 10'd336;
      15: return 10'd317;  16: return 10'd299;  17: return 10'd282;
      18: return 10'd267;  19: return 10'd252;  20: return 10'd237;
      21: return 10'd224;  22: return 10'd211;  23: return 10'd200;
      24: return 10'd188;  25: return 10'd178;  26: return 10'd168;
      27: return 10'd158;  28: return 10'd149;  29: return 10'd141;
      30: return 10'd133;  31: return 10'd126;  32: return 10'd118;
      33: return 10'd112;  34: return 10'd105;  35: return 10'd100;
      36: return 10'd94;   37: return 10'd89;   38: return 10'd84;
      39: return 10'd79;   40: return 10'd74;   41: return 10'd70;
      42: return 10'd66;   43: return 10'd63;   44: return 10'd59;
      45: return 10'd56;   46: return 10'd52;   47: return 10'd50;
      48: return 10'd47;
      default: return 10'd0;
    endcase
  endfunction

  assign neg_hyst   = -HYST;
  assign is_high    = (sample >= HYST);
  assign is_low     = (sample < neg_hyst);
  assign running    = (state == S_RUN_HIGH) || (state == S_RUN_LOW);
  assign count_inc  = count + 10'd1;
  assign rise       = sample_valid && (state == S_RUN_LOW) && is_high;
  // A crossing on the 1023rd sample wins over the timeout.
  assign timeout    = sample_valid && running && !rise && (count_inc == 10'd1023);
  assign note_valid = (note != NO_NOTE);

  // Crossing FSM and period counter; only a valid strobe advances it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      count      <= 10'd0;
      period     <= 10'd0;
      pend_p     <= 10'd0;
      pend_valid <= 1'b0;
    end else begin
      pend_valid <= 1'b0;
      if (sample_valid) begin
        case (state)
          S_IDLE: begin
            if (is_low) state <= S_ARM;
          end
          S_ARM: begin
            if (is_high) begin
              state <= S_RUN_HIGH;
              count <= 10'd0;
            end
          end
          S_RUN_HIGH: begin
            if (timeout) begin
              state <= S_IDLE;
              count <= 10'd0;
            end else begin
              count <= count_inc;
              if (is_low) state <= S_RUN_LOW;
            end
          end
          S_RUN_LOW: begin
            if (rise) begin
              period     <= count_inc;
              pend_p     <= count_inc;
              pend_valid <= 1'b1;
              count      <= 10'd0;
              state      <= S_RUN_HIGH;
            end else if (timeout) begin
              state <= S_IDLE;
              count <= 10'd0;
            end else begin
              count <= count_inc;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Out-of-range periods fall through every bin and stay at 63.
  always_comb begin
    cand_next = NO_NOTE;
    for (int k = 0; k < 48; k++) begin
      if ((pend_p <= bound(k)) && (pend_p > bound(k + 1))) cand_next = 6'(k);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cand_q     <= NO_NOTE;
      cand_valid <= 1'b0;
    end else begin
      cand_valid <= pend_valid;
      if (pend_valid) cand_q <= cand_next;
    end
  end

  // The note decision uses the tracker's next values so the note lands in
  // the same cycle the tracker reaches STABLE_N.
  always_comb begin
    trk_last_next = last_cand;
    trk_cnt_next  = stable_cnt;
    if (cand_valid) begin
      if (cand_q == last_cand) begin
        if (stable_cnt < STABLE_MAX) trk_cnt_next = stable_cnt + CW'(1);
      end else begin
        trk_last_next = cand_q;
        trk_cnt_next  = CW'(1);
      end
    end
  end

  assign update_note = cand_valid && (trk_cnt_next == STABLE_MAX) && (trk_last_next != note);

  // A timeout forces silence and forgets any partially built-up candidate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      note         <= NO_NOTE;
      note_changed <= 1'b0;
      last_cand    <= NO_NOTE;
      stable_cnt   <= '0;
    end else begin
      note_changed <= 1'b0;
      if (timeout) begin
        last_cand    <= NO_NOTE;
        stable_cnt   <= '0;
        note         <= NO_NOTE;
        note_changed <= (note != NO_NOTE);
      end else begin
        last_cand  <= trk_last_next;
        stable_cnt <= trk_cnt_next;
        if (update_note) begin
          note         <= trk_last_next;
          note_changed <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/note_detector.md
NOTE_DETECTOR -- requirements
Module: note_detector

Interface
REQ-001 Parameter HYST, 16'sd512: zero-crossing hysteresis threshold (signed magnitude).
REQ-002 Parameter STABLE_N, 3: number of consecutive identical period classifications required before the note output updates.
REQ-003 Port clk, input, 1: single system clock; all logic is rising-edge triggered.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port sample_valid, input, 1: one-cycle strobe qualifying sample (48 kHz nominal).
REQ-006 Port sample, input, 16: signed two's-complement audio sample.
REQ-007 Port note, output, 6: detected note index; 6'd63 means no note.
REQ-008 Port note_valid, output, 1: high when note != 63.
REQ-009 Port note_changed, output, 1: one-cycle pulse when note updates.
REQ-010 Port period, output, 10: last completed period, in samples.

Function
REQ-011 Note encoding SHALL be note = (octave-2)*12 + semitone (C=0 … B=11), giving 0 = C2 through 47 = B5; 48..62 are never produced.
REQ-012 The block SHALL change state only on cycles where sample_valid=1.
REQ-013 FSM states: IDLE, ARM, RUN_HIGH, RUN_LOW.
- IDLE -> ARM when sample < -HYST.
- ARM -> RUN_HIGH when sample >= HYST; count := 0.
- RUN_HIGH -> RUN_LOW when sample < -HYST.
- RUN_LOW -> RUN_HIGH when sample >= HYST; this is a rising crossing.
REQ-014 In RUN_HIGH and RUN_LOW, count (10 bits) SHALL increment on every valid sample.
REQ-015 On a rising crossing:
- P = incremented count value.
- period := P.
- count := 0.
- P is issued to the classifier.
REQ-016 Timeout: if the incremented count reaches 1023 without a rising crossing on that sample:
- the FSM SHALL go to IDLE;
- note := 63 (with a note_changed pulse if note was not already 63);
- the stability tracker SHALL be cleared.
REQ-017 If a rising crossing and count=1023 occur on the same sample, the crossing SHALL take priority and be classified normally (it yields 63).
REQ-018 Classifier:
- Boundary table B[k] = floor(48000 / (65.406·2^(k/12)·2^(-1/24))), k=0..48, held as constants; B[0]=755, B[33]=112, B[34]=105, B[45]=56, B[46]=52, B[48]=47.
- Candidate = k where B[k+1] < P <= B[k].
- P > 755 or P <= 47 -> candidate 63.
REQ-019 The candidate SHALL be registered one clk after the crossing cycle.
REQ-020 Stability tracker, evaluated one clk after the candidate is registered:
- candidate == last_cand: stable_cnt increments, saturating at STABLE_N.
- otherwise: last_cand := candidate and stable_cnt := 1.
REQ-021 When stable_cnt reaches STABLE_N and last_cand != note:
- note := last_cand;
- note_changed SHALL pulse for exactly one clk in that same cycle.
- Note latency is 2 clks after the qualifying crossing strobe.
REQ-022 An unchanged note SHALL never generate a note_changed pulse.
REQ-023 note_valid SHALL be combinational (note != 63).

Reset
REQ-024 On reset, regardless of clock, the following SHALL be applied:
- state := IDLE, count := 0, period := 0;
- note := 63, note_valid = 0, note_changed := 0;
- last_cand := 63, stable_cnt := 0.
REQ-025 Reset asserted mid-measurement SHALL discard the partial period, and the next measurement SHALL restart from IDLE.

Verification
REQ-026 Reset check: assert reset asynchronously between clock edges -> note=63, note_valid=0, period=0 immediately.
REQ-027 A4 lock:
- Stimulus: square wave ±8000, 55 samples high / 54 samples low, sample_valid every 4 clks.
- Response: period=109 at each crossing; note=33 with a single note_changed pulse 2 clks after the 3rd completed period; no further pulses.
REQ-028 Stability filter:
- From A4 lock, apply 2 periods of 55 samples then 1 period of 109 -> note stays 33.
- Then 3 periods of 55 -> note=45.
REQ-029 Silence timeout: from note=33, drive sample=±300 (below HYST) -> note=63 and note_changed pulse on the sample where count reaches 1023; FSM in IDLE.
REQ-030 Out of range: periods of 800 and 46 samples, 3 each -> note remains 63, period reports 800 / 46.
REQ-031 Strobe gating: hold sample_valid=0 for 5000 clks mid-period -> count, state and note unchanged, with no timeout.
